// File: rtl/esc_rx.sv
// esc_rx: ESC/servo PWM pulse-width decoder (988..2011 cycles -> val 0..1023); ESC_RX_FILTER_EN adds a 3-sample deglitch.
// Latency: vld on the 3rd tmr_1Mhz edge after sig is first sampled low (5 edges with the deglitch enabled).
// Backpressure: none; vld is a one-cycle strobe and val holds until the next accepted pulse.
module esc_rx #(
   parameter int PW_MIN  = 988,
   parameter int PW_LO   = 900,
   parameter int PW_HI   = 2100,
   parameter int TIMEOUT = 25000
) (
   input  logic       tmr_1Mhz,
   input  logic       rst,
   input  logic       sig,
   output logic [9:0] val,
   output logic       vld,
   output logic       lost
);

   typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;

   localparam logic [11:0] PW_LO_W  = 12'(PW_LO);
   localparam logic [11:0] PW_HI_W  = 12'(PW_HI);
   localparam logic [14:0] TO_W     = 15'(TIMEOUT);
   localparam logic signed [13:0] PW_MIN_S = 14'(PW_MIN);

   state_t             state;
   logic               sync0, sync1, s, s_prev;
   logic [11:0]        wid;
   logic [14:0]        to_cnt;
   logic [2:0]         prime;
   logic               primed, accept;
   logic signed [13:0] diff;
   logic [9:0]         val_c;

`ifdef ESC_RX_FILTER_EN
   localparam logic [2:0] PRIME = 3'd4;
   logic h1, h2;

   always_ff @(posedge tmr_1Mhz) begin
      if (rst) begin
         h1 <= 1'b0;
         h2 <= 1'b0;
      end else begin
         h1 <= sync1;
         h2 <= h1;
      end
   end

   // s follows the synchronized input only once three consecutive samples agree
   assign s = (sync1 == h1 && h1 == h2) ? sync1 : s_prev;
`else
   localparam logic [2:0] PRIME = 3'd2;
   assign s = sync1;
`endif

   always_ff @(posedge tmr_1Mhz) begin
      if (rst) begin
         sync0  <= 1'b0;
         sync1  <= 1'b0;
         s_prev <= 1'b0;
      end else begin
         sync0  <= sig;
         sync1  <= sync0;
         s_prev <= s;
      end
   end

   // s carries reset values until the input pipeline has refilled; a pulse already
   // high at reset release must not be mistaken for a fresh low phase
   assign primed = (prime == PRIME);

   assign accept = (state == HIGH) && !s && (wid >= PW_LO_W) && (wid <= PW_HI_W);
   assign diff   = $signed({2'b00, wid}) - PW_MIN_S;

   always_comb begin
      val_c = diff[9:0];
      if (diff < 14'sd0)
         val_c = 10'd0;
      else if (diff > 14'sd1023)
         val_c = 10'd1023;
   end

   always_ff @(posedge tmr_1Mhz) begin
      if (rst) begin
         state  <= WAIT_LOW;
         wid    <= 12'd0;
         val    <= 10'd0;
         vld    <= 1'b0;
         to_cnt <= 15'd0;
         lost   <= 1'b1;
         prime  <= 3'd0;
      end else begin
         vld <= 1'b0;
         if (!primed)
            prime <= prime + 3'd1;
         case (state)
            WAIT_LOW: if (primed && !s) state <= IDLE;
            IDLE: begin
               if (s && !s_prev) begin
                  state <= HIGH;
                  wid   <= 12'd1;
               end
            end
            HIGH: begin
               if (s) begin
                  if (wid >= PW_HI_W)
                     state <= WAIT_LOW;
                  else if (wid != 12'hFFF)
                     wid <= wid + 12'd1;
               end else begin
                  state <= IDLE;
                  if (accept) begin
                     val <= val_c;
                     vld <= 1'b1;
                  end
               end
            end
            default: state <= WAIT_LOW;
         endcase

         if (accept) begin
            to_cnt <= 15'd0;
            lost   <= 1'b0;
         end else if (to_cnt != TO_W) begin
            to_cnt <= to_cnt + 15'd1;
            if (to_cnt == TO_W - 15'd1)
               lost <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_esc_rx.sv
// Directed bench for esc_rx: pulses are driven from one initial block, expected decodes are queued
// at the falling edge and matched (value, arrival cycle, lost) by a monitor when vld fires.
module tb_esc_rx;

`ifdef ESC_RX_FILTER_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif

   logic       tmr_1Mhz = 1'b0;
   logic       rst = 1'b1;
   logic       sig = 1'b0;
   logic [9:0] val;
   logic       vld;
   logic       lost;

   typedef struct {
      int v;
      int due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   last_vld_cyc = 0;
   int   exp_val = 0;

   esc_rx dut (
      .tmr_1Mhz (tmr_1Mhz),
      .rst      (rst),
      .sig      (sig),
      .val      (val),
      .vld      (vld),
      .lost     (lost)
   );

   always #5 tmr_1Mhz = ~tmr_1Mhz;

   always @(posedge tmr_1Mhz) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Independent reading of the ESC mapping: 988 -> 0, clamped to 0..1023.
   function automatic int decode(input int w);
      int d;
      d = w - 988;
      if (d < 0) d = 0;
      if (d > 1023) d = 1023;
      return d;
   endfunction

   always @(negedge tmr_1Mhz) begin
      if (!rst && vld === 1'b1) begin
         exp_t e;
         chk("vld_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("vld_val", val, e.v);
            chk("vld_latency", cyc, e.due);
            chk("lost_clear_with_vld", lost, 0);
         end
         last_vld_cyc = cyc;
      end
   end

   task automatic pulse(input int hi, input int lo);
      exp_t e;
      @(negedge tmr_1Mhz);
      sig = 1'b1;
      repeat (hi) @(negedge tmr_1Mhz);
      sig = 1'b0;
      if (hi >= 900 && hi <= 2100) begin
         e.v   = decode(hi);
         e.due = cyc + LAT;
         sb.push_back(e);
         exp_val = e.v;
      end
      repeat (lo) @(negedge tmr_1Mhz);
      chk("val_hold", val, exp_val);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      int guard;

      // reset state
      rst = 1'b1;
      repeat (5) @(negedge tmr_1Mhz);
      chk("rst_val", val, 0);
      chk("rst_vld", vld, 0);
      chk("rst_lost", lost, 1);
      rst = 1'b0;
      repeat (10) @(negedge tmr_1Mhz);
      chk("lost_after_rst", lost, 1);

      // nominal endpoints
      pulse(988, 1512);
      pulse(1500, 1000);
      pulse(2011, 489);

      // range edges
      pulse(950, 1500);
      pulse(2050, 1500);
      pulse(850, 1500);
      pulse(2101, 1500);
      pulse(1500, 1000);
      pulse(900, 1000);
      pulse(899, 1000);
      pulse(2100, 1000);

      // loopback: command 300 at 400 Hz
      for (int k = 0; k < 4; k++) pulse(988 + 300, 2500 - 1288);
      chk("lost_loopback", lost, 0);

      // short glitch inside the low phase, then a normal pulse
      pulse(2, 1000);
      pulse(1500, 1000);

      // reset 500 cycles into a pulse, released while sig is still high
      @(negedge tmr_1Mhz);
      sig = 1'b1;
      repeat (500) @(negedge tmr_1Mhz);
      rst = 1'b1;
      repeat (3) @(negedge tmr_1Mhz);
      chk("midrst_vld", vld, 0);
      chk("midrst_val", val, 0);
      chk("midrst_lost", lost, 1);
      exp_val = 0;
      rst = 1'b0;
      repeat (400) @(negedge tmr_1Mhz);
      sig = 1'b0;
      repeat (1000) @(negedge tmr_1Mhz);
      chk("partial_no_vld", sb.size(), 0);
      chk("partial_val", val, 0);
      chk("partial_lost", lost, 1);
      pulse(1500, 1000);

      // timeout: lost rises exactly TIMEOUT cycles after the last vld
      chk("lost_before_timeout", lost, 0);
      guard = 0;
      while (lost !== 1'b1 && guard < 30000) begin
         @(negedge tmr_1Mhz);
         guard++;
      end
      chk("lost_rise_delay", cyc - last_vld_cyc, 25000);
      repeat (100) @(negedge tmr_1Mhz);
      chk("lost_held", lost, 1);
      pulse(1288, 1212);
      chk("lost_after_recover", lost, 0);

      chk("sb_final", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
